threewire_slave_ctrl: RTL and testbench

Three-wire bus slave (responder). It decodes frames issued by the threewire master on `tw_clock` / `tw_cs` / `tw_data` and turns them into single-cycle register-bus write strobes and read requests in the `in_clk` domain. For read frames it drives read data back onto the bidirectional data line. It sits between the external 3w pins and a local register file.

---
 rtl/threewire_slave_ctrl.sv | 275 +++++++++++++++++++++++++++
 tb/tb_threewire_slave_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/threewire_slave_ctrl.sv
// threewire_slave_ctrl: three-wire bus responder; decodes tw frames into register-bus write strobes / read requests.
// Latency: strobes land TWS_SYNC_STAGES+2 in_clk cycles after the qualifying tw_clock rise; in_rd_data captured 1 cycle after out_rd_req.
// Backpressure: none; the register file must take a strobe on any cycle and return read data on the fixed cycle.
// Optional saturating abort counter is built only when THREEWIRE_SLAVE_ABORT_CNT_EN is defined.

module threewire_slave_ctrl #(
  parameter int TWS_ADDRESS_BITS = 10,
  parameter int TWS_DATA_BITS    = 32,
  parameter int TWS_SYNC_STAGES  = 2
) (
  input  logic                        in_clk,
  input  logic                        in_rst,
  input  logic                        in_tw_clock,
  input  logic                        in_tw_cs,
  inout  wire                         io_tw_data,
  output logic [TWS_ADDRESS_BITS-1:0] out_addr,
  output logic [TWS_DATA_BITS-1:0]    out_wr_data,
  output logic                        out_wr_strobe,
  output logic                        out_rd_req,
  input  logic [TWS_DATA_BITS-1:0]    in_rd_data,
  output logic                        out_busy,
  output logic [7:0]                  out_abort_cnt
);

  // One shift register serves both the address and the data field.
  localparam int SHW = (TWS_ADDRESS_BITS > TWS_DATA_BITS) ? TWS_ADDRESS_BITS : TWS_DATA_BITS;
  localparam int CW  = (SHW > 1) ? $clog2(SHW) : 1;
  localparam logic [CW-1:0] CNT_ADDR = CW'(TWS_ADDRESS_BITS - 1);
  localparam logic [CW-1:0] CNT_DATA = CW'(TWS_DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RW       = 3'd1,
    S_ADDR     = 3'd2,
    S_WR_DATA  = 3'd3,
    S_RD_FETCH = 3'd4,
    S_RD_DRIVE = 3'd5,
    S_DONE     = 3'd6
  } state_t;

  // synchronisers and edge history
  logic [TWS_SYNC_STAGES-1:0] r_clk_sync;
  logic [TWS_SYNC_STAGES-1:0] r_cs_sync;
  logic [TWS_SYNC_STAGES-1:0] r_dat_sync;
  logic                       r_clk_hist;
  logic                       r_cs_hist;

  logic w_clk_s;
  logic w_cs_s;
  logic w_dat_s;
  logic w_rise;
  logic w_fall;
  logic w_cs_fall;
  logic w_active;

  // frame state
  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_rw;
  logic                  w_rw_nxt;
  logic [SHW-1:0]        r_shift;
  logic [SHW-1:0]        w_shift_nxt;
  logic [SHW-1:0]        w_shift_in;
  logic [CW-1:0]         r_cnt;
  logic [CW-1:0]         w_cnt_nxt;
  logic [TWS_ADDRESS_BITS-1:0] r_addr;
  logic [TWS_ADDRESS_BITS-1:0] w_addr_nxt;
  logic [TWS_DATA_BITS-1:0]    r_wr_data;
  logic [TWS_DATA_BITS-1:0]    w_wr_data_nxt;
  logic                  r_wr_strobe;
  logic                  w_wr_strobe_nxt;
  logic                  r_rd_req;
  logic                  w_rd_req_nxt;
  logic                  r_loaded;
  logic                  w_loaded_nxt;
  logic                  r_busy;
  logic                  w_busy_nxt;

  // Bring the three pins into in_clk. The cs chain resets to "selected" so that a
  // cs held low across reset never looks like a falling edge: a new frame needs
  // the master to deselect and reselect.
  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      r_clk_sync <= '0;
      r_cs_sync  <= '0;
      r_dat_sync <= '0;
      r_clk_hist <= 1'b0;
      r_cs_hist  <= 1'b0;
    end else begin
      r_clk_sync <= {r_clk_sync[TWS_SYNC_STAGES-2:0], in_tw_clock};
      r_cs_sync  <= {r_cs_sync[TWS_SYNC_STAGES-2:0], in_tw_cs};
      r_dat_sync <= {r_dat_sync[TWS_SYNC_STAGES-2:0], io_tw_data};
      r_clk_hist <= r_clk_sync[TWS_SYNC_STAGES-1];
      r_cs_hist  <= r_cs_sync[TWS_SYNC_STAGES-1];
    end
  end

  assign w_clk_s   = r_clk_sync[TWS_SYNC_STAGES-1];
  assign w_cs_s    = r_cs_sync[TWS_SYNC_STAGES-1];
  assign w_dat_s   = r_dat_sync[TWS_SYNC_STAGES-1];
  assign w_rise    =  w_clk_s & ~r_clk_hist;
  assign w_fall    = ~w_clk_s &  r_clk_hist;
  assign w_cs_fall = ~w_cs_s  &  r_cs_hist;

  // States in which a cs release counts as an aborted frame.
  assign w_active = (r_state == S_RW) || (r_state == S_ADDR) || (r_state == S_WR_DATA) ||
                    (r_state == S_RD_FETCH) || (r_state == S_RD_DRIVE);

  assign w_shift_in = {r_shift[SHW-2:0], w_dat_s};

  // FSM state register
  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and datapath updates; an abort overrides whatever the state would have done.
  always_comb begin
    w_state_nxt     = r_state;
    w_rw_nxt        = r_rw;
    w_shift_nxt     = r_shift;
    w_cnt_nxt       = r_cnt;
    w_addr_nxt      = r_addr;
    w_wr_data_nxt   = r_wr_data;
    w_wr_strobe_nxt = 1'b0;
    w_rd_req_nxt    = 1'b0;
    w_loaded_nxt    = r_loaded;
    w_busy_nxt      = r_busy;

    case (r_state)
      S_IDLE: begin
        if (w_cs_fall) begin
          w_state_nxt = S_RW;
          w_busy_nxt  = 1'b1;
        end
      end
      S_RW: begin
        if (w_rise) begin
          w_rw_nxt    = w_dat_s;
          w_cnt_nxt   = CNT_ADDR;
          w_state_nxt = S_ADDR;
        end
      end
      S_ADDR: begin
        if (w_rise) begin
          w_shift_nxt = w_shift_in;
          if (r_cnt == '0) begin
            w_addr_nxt = w_shift_in[TWS_ADDRESS_BITS-1:0];
            if (r_rw) begin
              w_cnt_nxt   = CNT_DATA;
              w_state_nxt = S_WR_DATA;
            end else begin
              w_rd_req_nxt = 1'b1;
              w_loaded_nxt = 1'b0;
              w_state_nxt  = S_RD_FETCH;
            end
          end else begin
            w_cnt_nxt = r_cnt - CW'(1);
          end
        end
      end
      S_WR_DATA: begin
        if (w_rise) begin
          w_shift_nxt = w_shift_in;
          if (r_cnt == '0) begin
            w_wr_data_nxt   = w_shift_in[TWS_DATA_BITS-1:0];
            w_wr_strobe_nxt = 1'b1;
            w_state_nxt     = S_DONE;
          end else begin
            w_cnt_nxt = r_cnt - CW'(1);
          end
        end
      end
      S_RD_FETCH: begin
        // First cycle here is the out_rd_req cycle; the register file answers on the next one.
        if (!r_loaded && !r_rd_req) begin
          w_shift_nxt                      = '0;
          w_shift_nxt[TWS_DATA_BITS-1:0]   = in_rd_data;
          w_cnt_nxt                        = CNT_DATA;
          w_loaded_nxt                     = 1'b1;
        end else if (r_loaded && w_fall) begin
          // Turnaround fall: master has released the line, start driving the MSB.
          w_state_nxt = S_RD_DRIVE;
        end
      end
      S_RD_DRIVE: begin
        if (w_fall) begin
          if (r_cnt == '0) begin
            w_state_nxt = S_DONE;
          end else begin
            w_shift_nxt = {r_shift[SHW-2:0], 1'b0};
            w_cnt_nxt   = r_cnt - CW'(1);
          end
        end
      end
      S_DONE: begin
        if (w_cs_s) begin
          w_state_nxt = S_IDLE;
          w_busy_nxt  = 1'b0;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_busy_nxt  = 1'b0;
      end
    endcase

    if (w_active && w_cs_s) begin
      w_state_nxt     = S_IDLE;
      w_busy_nxt      = 1'b0;
      w_wr_strobe_nxt = 1'b0;
      w_rd_req_nxt    = 1'b0;
      w_addr_nxt      = r_addr;
      w_wr_data_nxt   = r_wr_data;
    end
  end

  // Datapath registers
  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      r_rw        <= 1'b0;
      r_shift     <= '0;
      r_cnt       <= '0;
      r_addr      <= '0;
      r_wr_data   <= '0;
      r_wr_strobe <= 1'b0;
      r_rd_req    <= 1'b0;
      r_loaded    <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_rw        <= w_rw_nxt;
      r_shift     <= w_shift_nxt;
      r_cnt       <= w_cnt_nxt;
      r_addr      <= w_addr_nxt;
      r_wr_data   <= w_wr_data_nxt;
      r_wr_strobe <= w_wr_strobe_nxt;
      r_rd_req    <= w_rd_req_nxt;
      r_loaded    <= w_loaded_nxt;
      r_busy      <= w_busy_nxt;
    end
  end

`ifdef THREEWIRE_SLAVE_ABORT_CNT_EN
  logic       w_abort;
  logic [7:0] r_abort_cnt;

  assign w_abort = w_active & w_cs_s;

  // Saturating count of frames the master abandoned mid-flight.
  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      r_abort_cnt <= 8'd0;
    end else if (w_abort && (r_abort_cnt != 8'hFF)) begin
      r_abort_cnt <= r_abort_cnt + 8'd1;
    end
  end

  assign out_abort_cnt = r_abort_cnt;
`else
  assign out_abort_cnt = 8'd0;
`endif

  // The line is only ever driven while shifting read data out.
  assign io_tw_data = (r_state == S_RD_DRIVE) ? r_shift[TWS_DATA_BITS-1] : 1'bz;

  assign out_addr      = r_addr;
  assign out_wr_data   = r_wr_data;
  assign out_wr_strobe = r_wr_strobe;
  assign out_rd_req    = r_rd_req;
  assign out_busy      = r_busy;

endmodule

// File: tb/tb_threewire_slave_ctrl.sv
// tb_threewire_slave_ctrl: bit-banged three-wire master plus frame-level reference model.
// Latency: master half-period is H in_clk cycles, above the slave's minimum.
// Backpressure: none; the bench answers read requests on the cycle after out_rd_req.

module tb_threewire_slave_ctrl;
  localparam int A = 10;
  localparam int D = 32;
  localparam int H = 6;

  logic         in_clk = 1'b0;
  logic         in_rst;
  logic         in_tw_clock;
  logic         in_tw_cs;
  wire          io_tw_data;
  logic [A-1:0] out_addr;
  logic [D-1:0] out_wr_data;
  logic         out_wr_strobe;
  logic         out_rd_req;
  logic [D-1:0] in_rd_data;
  logic         out_busy;
  logic [7:0]   out_abort_cnt;

  logic         m_drv;
  logic         m_bit;
  logic [D-1:0] rd_value;
  logic         rq_seen = 1'b0;

  int n_vec   = 0;
  int n_err   = 0;
  int both_hi = 0;
  int aborts  = 0;
  logic [A-1:0] last_addr;
  logic [D-1:0] last_wr;

  logic [A-1:0] obs_wr_addr[$];
  logic [D-1:0] obs_wr_data[$];
  logic [A-1:0] obs_rd_addr[$];

  assign io_tw_data = m_drv ? m_bit : 1'bz;
  pulldown (io_tw_data);

  threewire_slave_ctrl #(
    .TWS_ADDRESS_BITS(A),
    .TWS_DATA_BITS(D),
    .TWS_SYNC_STAGES(2)
  ) dut (
    .in_clk(in_clk),
    .in_rst(in_rst),
    .in_tw_clock(in_tw_clock),
    .in_tw_cs(in_tw_cs),
    .io_tw_data(io_tw_data),
    .out_addr(out_addr),
    .out_wr_data(out_wr_data),
    .out_wr_strobe(out_wr_strobe),
    .out_rd_req(out_rd_req),
    .in_rd_data(in_rd_data),
    .out_busy(out_busy),
    .out_abort_cnt(out_abort_cnt)
  );

  always #5 in_clk = ~in_clk;

  // Record register-bus events away from the active edge.
  always @(negedge in_clk) begin
    if (out_wr_strobe) begin
      obs_wr_addr.push_back(out_addr);
      obs_wr_data.push_back(out_wr_data);
    end
    if (out_rd_req) obs_rd_addr.push_back(out_addr);
    if (out_wr_strobe && out_rd_req) both_hi++;
    rq_seen = out_rd_req;
  end

  // Register file: read data is valid only in the cycle after out_rd_req, garbage otherwise.
  initial begin
    in_rd_data = '0;
    forever begin
      @(posedge in_clk);
      #1;
      in_rd_data = rq_seen ? rd_value : ~rd_value;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge in_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_abort();
`ifdef THREEWIRE_SLAVE_ABORT_CNT_EN
    return (aborts > 255) ? 8'd255 : 8'(aborts);
`else
    return 8'd0;
`endif
  endfunction

  task automatic chk_reset(input string tag);
    chk({tag, "_addr"},   64'(out_addr), 64'd0);
    chk({tag, "_wdata"},  64'(out_wr_data), 64'd0);
    chk({tag, "_strobe"}, 64'(out_wr_strobe), 64'd0);
    chk({tag, "_rdreq"},  64'(out_rd_req), 64'd0);
    chk({tag, "_busy"},   64'(out_busy), 64'd0);
    chk({tag, "_abort"},  64'(out_abort_cnt), 64'd0);
    chk({tag, "_line"},   64'(io_tw_data), 64'd0);
  endtask

  // Drive one frame. abort_bits >= 0: release cs after that many bits. rst_bit >= 0:
  // pulse in_rst while the slave drives that read bit.
  task automatic frame(input bit rw, input logic [A-1:0] addr, input logic [D-1:0] wdata,
                       input int abort_bits, input int rst_bit, output logic [D-1:0] rdata);
    logic [A+D:0] v;
    int nb;
    v  = {rw, addr, wdata};
    nb = rw ? (1 + A + D) : (1 + A);
    rdata = '0;
    in_tw_cs = 1'b0;
    m_drv = 1'b1;
    m_bit = v[A+D];
    cyc(H);
    chk("busy_in_frame", 64'(out_busy), 64'd1);
    for (int i = 0; i < nb; i++) begin
      if (i == abort_bits) begin
        cyc(2);
        m_drv = 1'b0;
        in_tw_cs = 1'b1;
        cyc(H + 2);
        return;
      end
      m_bit = v[A+D-i];
      cyc(H);
      in_tw_clock = 1'b1;
      chk("line_master_owned", 64'(io_tw_data), 64'(m_bit));
      cyc(H);
      in_tw_clock = 1'b0;
      if (!rw && i == nb - 1) m_drv = 1'b0;
    end
    if (!rw && abort_bits == nb) begin
      cyc(2);
      in_tw_cs = 1'b1;
      cyc(H + 2);
      return;
    end
    if (!rw) begin
      cyc(1);
      chk("line_before_turnaround", 64'(io_tw_data), 64'd0);
      cyc(H - 1);
      for (int k = D - 1; k >= 0; k--) begin
        if (k == rst_bit) begin
          in_rst = 1'b1;
          cyc(1);
          chk_reset("mid_frame_rst");
          in_rst = 1'b0;
          cyc(2);
          in_tw_cs = 1'b1;
          cyc(H + 2);
          return;
        end
        in_tw_clock = 1'b1;
        rdata[k] = io_tw_data;
        cyc(H);
        in_tw_clock = 1'b0;
        cyc(H);
      end
      chk("line_after_last_bit", 64'(io_tw_data), 64'd0);
    end else begin
      cyc(H);
      m_drv = 1'b0;
    end
    in_tw_cs = 1'b1;
    cyc(H + 2);
  endtask

  // Run a frame and compare the slave's behaviour with the frame-level rules.
  task automatic run(input bit rw, input logic [A-1:0] addr, input logic [D-1:0] wdata,
                     input logic [D-1:0] rval, input int abort_bits, input int rst_bit);
    logic [D-1:0] rdata;
    bit aborted, addr_done, exp_wr, exp_rd;
    obs_wr_addr.delete();
    obs_wr_data.delete();
    obs_rd_addr.delete();
    rd_value = rval;
    frame(rw, addr, wdata, abort_bits, rst_bit, rdata);

    aborted   = (abort_bits >= 0);
    addr_done = !aborted || (abort_bits >= 1 + A);
    exp_wr    = rw && !aborted;
    exp_rd    = !rw && addr_done;
    if (addr_done) last_addr = addr;
    if (exp_wr) last_wr = wdata;
    if (aborted) aborts++;
    if (rst_bit >= 0) begin
      last_addr = '0;
      last_wr   = '0;
      aborts    = 0;
    end

    chk("wr_strobe_count", 64'(obs_wr_addr.size()), 64'(exp_wr));
    if (exp_wr && obs_wr_addr.size() == 1) begin
      chk("wr_addr", 64'(obs_wr_addr[0]), 64'(addr));
      chk("wr_data", 64'(obs_wr_data[0]), 64'(wdata));
    end
    chk("rd_req_count", 64'(obs_rd_addr.size()), 64'(exp_rd));
    if (exp_rd && obs_rd_addr.size() == 1) chk("rd_addr", 64'(obs_rd_addr[0]), 64'(addr));
    if (!rw && !aborted && rst_bit < 0) chk("rd_data_captured", 64'(rdata), 64'(rval));
    chk("addr_hold", 64'(out_addr), 64'(last_addr));
    chk("wr_data_hold", 64'(out_wr_data), 64'(last_wr));
    chk("abort_cnt", 64'(out_abort_cnt), 64'(exp_abort()));
    chk("busy_after_frame", 64'(out_busy), 64'd0);
    chk("line_idle", 64'(io_tw_data), 64'd0);
  endtask

  initial begin
    in_rst      = 1'b1;
    in_tw_clock = 1'b0;
    in_tw_cs    = 1'b1;
    m_drv       = 1'b0;
    m_bit       = 1'b0;
    rd_value    = '0;
    last_addr   = '0;
    last_wr     = '0;
    cyc(3);
    chk_reset("reset");
    in_rst = 1'b0;
    cyc(H);

    run(1'b1, 10'h2A5, 32'hDEADBEEF, 32'h0, -1, -1);
    run(1'b0, 10'h013, 32'h0, 32'hA5A50F0F, -1, -1);
    run(1'b1, 10'h001, 32'h00000001, 32'h0, -1, -1);
    run(1'b0, 10'h3FF, 32'h0, 32'h80000001, -1, -1);
    run(1'b1, 10'h1C6, 32'h600DF00D, 32'h0, 6, -1);
    run(1'b1, 10'h0F0, 32'h13579BDF, 32'h0, -1, -1);

    for (int n = 0; n < 30; n++) begin
      bit rw;
      int ab;
      rw = 1'($urandom_range(0, 1));
      ab = -1;
      if ($urandom_range(0, 3) == 0) ab = rw ? int'($urandom_range(0, A + D)) : int'($urandom_range(0, 1 + A));
      run(rw, A'($urandom), $urandom, $urandom, ab, -1);
    end

    for (int n = 0; n < 300; n++) begin
      in_tw_cs = 1'b0;
      cyc(H);
      in_tw_cs = 1'b1;
      cyc(H);
      aborts++;
      if (aborts == 255) chk("abort_cnt_at_255", 64'(out_abort_cnt), 64'(exp_abort()));
    end
    chk("abort_cnt_saturated", 64'(out_abort_cnt), 64'(exp_abort()));

    run(1'b0, 10'h155, 32'h0, 32'h5A5AF0F0, -1, 20);
    run(1'b0, 10'h2C3, 32'h0, 32'h12345678, -1, -1);

    chk("strobe_and_rdreq_overlap", 64'(both_hi), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
